// File: rtl/id_operand_stage_if.sv
// ID-side instruction bundle and the ID/EX register outputs of the operand stage.
// The slave side is the operand stage; the master side is whoever drives decode and consumes ID/EX.
interface id_operand_stage_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5
);
   logic            in_valid;
   logic [REGW-1:0] in_rs1;
   logic [REGW-1:0] in_rs2;
   logic            in_use_rs1;
   logic            in_use_rs2;
   logic [REGW-1:0] in_rd;
   logic            in_reg_write;
   logic            in_is_load;
   logic            stall;
   logic            out_valid;
   logic [XLEN-1:0] out_op1;
   logic [XLEN-1:0] out_op2;
   logic [REGW-1:0] out_rd;
   logic            out_reg_write;
   logic            out_is_load;

   modport master (
      output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_reg_write, in_is_load,
      input  stall, out_valid, out_op1, out_op2, out_rd, out_reg_write, out_is_load
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_reg_write, in_is_load,
      output stall, out_valid, out_op1, out_op2, out_rd, out_reg_write, out_is_load
   );
endinterface

// File: rtl/id_operand_stage.sv
// Decode operand stage: register-file addressing, EX/MEM/WB forwarding, load-use stall
// detection and the ID/EX pipeline register.
module id_operand_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic                clk,
   input  logic                rst,
   id_operand_stage_if.slave   id,
   input  logic                flush,
   output logic [REGW-1:0]     rf_src1_addr,
   output logic [REGW-1:0]     rf_src2_addr,
   input  logic [XLEN-1:0]     rf_src1_data,
   input  logic [XLEN-1:0]     rf_src2_data,
   input  logic [XLEN-1:0]     ex_result,
   input  logic [REGW-1:0]     mem_rd,
   input  logic                mem_reg_write,
   input  logic [XLEN-1:0]     mem_result,
   input  logic [REGW-1:0]     wb_rd,
   input  logic                wb_write_en,
   input  logic [XLEN-1:0]     wb_data,
   output logic [CNTW-1:0]     stall_count
);

   logic            hazard;
   logic            stall_int;
   logic            ex_fwd_ok;
   logic [XLEN-1:0] op1_sel;
   logic [XLEN-1:0] op2_sel;

   // Youngest producer wins; WB is needed because the register file write lands at the same edge as our read.
   function automatic logic [XLEN-1:0] pick_operand(
      input logic [REGW-1:0] idx,
      input logic [XLEN-1:0] rf_data,
      input logic            ex_ok,
      input logic [REGW-1:0] ex_rd,
      input logic [XLEN-1:0] ex_val,
      input logic            mem_ok,
      input logic [REGW-1:0] m_rd,
      input logic [XLEN-1:0] m_val,
      input logic            wb_ok,
      input logic [REGW-1:0] w_rd,
      input logic [XLEN-1:0] w_val
   );
      logic [XLEN-1:0] result;
      if (idx == '0)
         result = '0;
      else if (ex_ok && ex_rd == idx)
         result = ex_val;
      else if (mem_ok && m_rd == idx)
         result = m_val;
      else if (wb_ok && w_rd == idx)
         result = w_val;
      else
         result = rf_data;
      return result;
   endfunction

   assign rf_src1_addr = id.in_rs1;
   assign rf_src2_addr = id.in_rs2;

   always_comb begin
      hazard    = 1'b0;
      stall_int = 1'b0;
      ex_fwd_ok = id.out_valid & id.out_reg_write & ~id.out_is_load;
      // A load in ID/EX has no data yet, so a dependent reader must wait one cycle for MEM.
      if (id.out_valid && id.out_is_load && id.out_rd != '0 && id.in_valid)
         hazard = (id.in_use_rs1 && id.in_rs1 == id.out_rd) ||
                  (id.in_use_rs2 && id.in_rs2 == id.out_rd);
      stall_int = hazard & ~flush;
      op1_sel = pick_operand(id.in_rs1, rf_src1_data, ex_fwd_ok, id.out_rd, ex_result,
                             mem_reg_write, mem_rd, mem_result, wb_write_en, wb_rd, wb_data);
      op2_sel = pick_operand(id.in_rs2, rf_src2_data, ex_fwd_ok, id.out_rd, ex_result,
                             mem_reg_write, mem_rd, mem_result, wb_write_en, wb_rd, wb_data);
   end

   assign id.stall = stall_int;

   // Flush and stall both insert a bubble; operand/rd fields are left holding since they are ignored while invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         id.out_valid     <= 1'b0;
         id.out_op1       <= '0;
         id.out_op2       <= '0;
         id.out_rd        <= '0;
         id.out_reg_write <= 1'b0;
         id.out_is_load   <= 1'b0;
         stall_count      <= '0;
      end else if (flush || stall_int) begin
         id.out_valid     <= 1'b0;
         id.out_reg_write <= 1'b0;
         id.out_is_load   <= 1'b0;
         if (stall_int && stall_count != {CNTW{1'b1}})
            stall_count <= stall_count + CNTW'(1);
      end else begin
         id.out_valid     <= id.in_valid;
         id.out_op1       <= op1_sel;
         id.out_op2       <= op2_sel;
         id.out_rd        <= id.in_rd;
         id.out_reg_write <= id.in_valid & id.in_reg_write;
         id.out_is_load   <= id.in_valid & id.in_is_load;
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed hazard/forwarding scenarios followed by
// randomized traffic, all compared against a behavioural model of the pipeline stage.
module tb_id_operand_stage;

   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int CNTW = 4;
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   logic            clk;
   logic            rst;
   logic            flush;
   logic [REGW-1:0] rf_src1_addr, rf_src2_addr;
   logic [XLEN-1:0] rf_src1_data, rf_src2_data;
   logic [XLEN-1:0] ex_result;
   logic [REGW-1:0] mem_rd;
   logic            mem_reg_write;
   logic [XLEN-1:0] mem_result;
   logic [REGW-1:0] wb_rd;
   logic            wb_write_en;
   logic [XLEN-1:0] wb_data;
   logic [CNTW-1:0] stall_count;

   int checkCount = 0;
   int errCount   = 0;

   // Behavioural image of the ID/EX register contents.
   logic            mValid, mRegWrite, mIsLoad;
   logic [REGW-1:0] mRd;
   logic [XLEN-1:0] mOp1, mOp2;
   int              mStalls;

   id_operand_stage_if #(.XLEN(XLEN), .REGW(REGW)) idif ();

   id_operand_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
      .clk           (clk),
      .rst           (rst),
      .id            (idif.slave),
      .flush         (flush),
      .rf_src1_addr  (rf_src1_addr),
      .rf_src2_addr  (rf_src2_addr),
      .rf_src1_data  (rf_src1_data),
      .rf_src2_data  (rf_src2_data),
      .ex_result     (ex_result),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_write_en   (wb_write_en),
      .wb_data       (wb_data),
      .stall_count   (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Producers are listed youngest first; the first one that writes idx supplies the value.
   function automatic logic [XLEN-1:0] modelOperand(input logic [REGW-1:0] idx, input logic [XLEN-1:0] rf);
      logic            writes [3];
      logic [REGW-1:0] dest   [3];
      logic [XLEN-1:0] value  [3];
      writes[0] = mValid && mRegWrite && !mIsLoad; dest[0] = mRd;    value[0] = ex_result;
      writes[1] = mem_reg_write;                   dest[1] = mem_rd; value[1] = mem_result;
      writes[2] = wb_write_en;                     dest[2] = wb_rd;  value[2] = wb_data;
      if (idx == 0) return '0;
      for (int i = 0; i < 3; i++)
         if (writes[i] && dest[i] == idx) return value[i];
      return rf;
   endfunction

   function automatic logic modelHazard();
      logic readsLoadDest;
      readsLoadDest = (idif.in_use_rs1 && idif.in_rs1 == mRd) || (idif.in_use_rs2 && idif.in_rs2 == mRd);
      return mValid && mIsLoad && mRd != 0 && idif.in_valid && readsLoadDest;
   endfunction

   task automatic quietInputs();
      idif.in_valid = 0; idif.in_rs1 = 0; idif.in_rs2 = 0; idif.in_use_rs1 = 0; idif.in_use_rs2 = 0;
      idif.in_rd = 0; idif.in_reg_write = 0; idif.in_is_load = 0;
      rst = 0; flush = 0; rf_src1_data = 0; rf_src2_data = 0; ex_result = 0;
      mem_rd = 0; mem_reg_write = 0; mem_result = 0; wb_rd = 0; wb_write_en = 0; wb_data = 0;
   endtask

   task automatic randomInputs();
      idif.in_valid     = ($urandom_range(9) != 0);
      idif.in_rs1       = REGW'($urandom_range(4));
      idif.in_rs2       = REGW'($urandom_range(4));
      idif.in_use_rs1   = $urandom_range(1);
      idif.in_use_rs2   = $urandom_range(1);
      idif.in_rd        = REGW'($urandom_range(4));
      idif.in_reg_write = $urandom_range(1);
      idif.in_is_load   = ($urandom_range(2) == 0);
      flush             = ($urandom_range(9) == 0);
      rst               = ($urandom_range(49) == 0);
      rf_src1_data      = $urandom;
      rf_src2_data      = $urandom;
      ex_result         = $urandom;
      mem_rd            = REGW'($urandom_range(4));
      mem_reg_write     = $urandom_range(1);
      mem_result        = $urandom;
      wb_rd             = REGW'($urandom_range(4));
      wb_write_en       = $urandom_range(1);
      wb_data           = $urandom;
   endtask

   // Checks the combinational outputs, clocks one edge, updates the model and checks ID/EX.
   task automatic applyStimulus();
      logic            expStall;
      logic [XLEN-1:0] expOp1, expOp2;
      #1;
      expStall = modelHazard() && !flush;
      expOp1   = modelOperand(idif.in_rs1, rf_src1_data);
      expOp2   = modelOperand(idif.in_rs2, rf_src2_data);
      checkOutput("stall", idif.stall, expStall);
      checkOutput("rf_src1_addr", rf_src1_addr, idif.in_rs1);
      checkOutput("rf_src2_addr", rf_src2_addr, idif.in_rs2);
      @(posedge clk);
      if (rst) begin
         mValid = 0; mRegWrite = 0; mIsLoad = 0; mRd = 0; mOp1 = 0; mOp2 = 0; mStalls = 0;
      end else if (flush || expStall) begin
         mValid = 0; mRegWrite = 0; mIsLoad = 0;
         if (expStall) mStalls++;
      end else begin
         mValid    = idif.in_valid;
         mOp1      = expOp1;
         mOp2      = expOp2;
         mRd       = idif.in_rd;
         mRegWrite = idif.in_valid && idif.in_reg_write;
         mIsLoad   = idif.in_valid && idif.in_is_load;
      end
      #1;
      checkOutput("out_valid", idif.out_valid, mValid);
      checkOutput("out_reg_write", idif.out_reg_write, mRegWrite);
      checkOutput("out_is_load", idif.out_is_load, mIsLoad);
      checkOutput("stall_count", stall_count, (mStalls > int'(CNT_MAX)) ? CNT_MAX : CNTW'(mStalls));
      if (mValid) begin
         checkOutput("out_rd", idif.out_rd, mRd);
         checkOutput("out_op1", idif.out_op1, mOp1);
         checkOutput("out_op2", idif.out_op2, mOp2);
      end
   endtask

   task automatic issue(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2, input logic [REGW-1:0] rd,
                        input logic regWrite, input logic isLoad);
      idif.in_valid = 1; idif.in_rs1 = rs1; idif.in_rs2 = rs2;
      idif.in_use_rs1 = (rs1 != 0); idif.in_use_rs2 = (rs2 != 0);
      idif.in_rd = rd; idif.in_reg_write = regWrite; idif.in_is_load = isLoad;
   endtask

   initial begin
      logic [CNTW-1:0] savedCount;
      quietInputs();
      rst = 1;
      randomInputs();
      rst = 1;
      @(posedge clk);
      #1;
      mValid = 0; mRegWrite = 0; mIsLoad = 0; mRd = 0; mOp1 = 0; mOp2 = 0; mStalls = 0;
      for (int i = 0; i < 2; i++) begin
         randomInputs();
         rst = 1;
         applyStimulus();
      end
      checkOutput("reset_valid", idif.out_valid, 0);
      checkOutput("reset_op1", idif.out_op1, 0);
      checkOutput("reset_count", stall_count, 0);

      $display("[TB] EX forwarding");
      quietInputs();
      issue(0, 0, 5, 1, 0);
      applyStimulus();
      issue(5, 0, 6, 1, 0);
      ex_result = 32'h1234; rf_src1_data = 32'hDEAD;
      applyStimulus();
      checkOutput("ex_fwd_op1", idif.out_op1, 32'h1234);

      $display("[TB] forwarding priority");
      quietInputs();
      issue(0, 0, 7, 1, 0);
      applyStimulus();
      issue(7, 0, 0, 1, 0);
      ex_result = 32'hA; mem_rd = 7; mem_reg_write = 1; mem_result = 32'hB;
      wb_rd = 7; wb_write_en = 1; wb_data = 32'hC; rf_src1_data = 32'hFF;
      applyStimulus();
      checkOutput("prio_ex", idif.out_op1, 32'hA);
      applyStimulus();
      checkOutput("prio_mem", idif.out_op1, 32'hB);
      mem_reg_write = 0;
      applyStimulus();
      checkOutput("prio_wb", idif.out_op1, 32'hC);
      issue(0, 0, 0, 1, 0);
      mem_rd = 0; mem_reg_write = 1; wb_rd = 0;
      applyStimulus();
      checkOutput("prio_x0", idif.out_op1, 0);

      $display("[TB] load-use");
      quietInputs();
      issue(0, 0, 3, 1, 1);
      applyStimulus();
      issue(3, 3, 4, 1, 0);
      savedCount = stall_count;
      #1 checkOutput("lu_stall", idif.stall, 1);
      applyStimulus();
      checkOutput("lu_bubble", idif.out_valid, 0);
      checkOutput("lu_count", stall_count, savedCount + CNTW'(1));
      mem_rd = 3; mem_reg_write = 1; mem_result = 32'h55;
      #1 checkOutput("lu_nostall", idif.stall, 0);
      applyStimulus();
      checkOutput("lu_op1", idif.out_op1, 32'h55);
      checkOutput("lu_op2", idif.out_op2, 32'h55);
      checkOutput("lu_valid", idif.out_valid, 1);

      $display("[TB] flush during hazard");
      quietInputs();
      issue(0, 0, 3, 1, 1);
      applyStimulus();
      issue(3, 0, 4, 1, 0);
      flush = 1;
      savedCount = stall_count;
      #1 checkOutput("fl_stall", idif.stall, 0);
      applyStimulus();
      checkOutput("fl_valid", idif.out_valid, 0);
      checkOutput("fl_count", stall_count, savedCount);

      $display("[TB] saturation");
      for (int i = 0; i < 20; i++) begin
         quietInputs();
         issue(0, 0, 2, 1, 1);
         applyStimulus();
         issue(0, 2, 8, 1, 0);
         applyStimulus();
      end
      checkOutput("sat_count", stall_count, CNT_MAX);
      quietInputs();
      issue(0, 0, 2, 1, 1);
      applyStimulus();
      issue(2, 0, 8, 1, 0);
      rst = 1;
      applyStimulus();
      checkOutput("rst_mid_count", stall_count, 0);
      checkOutput("rst_mid_valid", idif.out_valid, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         randomInputs();
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
